// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max-pool over N_CH parallel Q4.6 channels, fed in raster order.
// Define RELU_EN to clamp negative inputs to zero before pooling; otherwise the pool is over raw signed values.
module relu_maxpool_2x2 #(
  parameter int N_CH       = 16,
  parameter int DATA_W     = 10,
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30
) (
  input  logic                        clk_i,
  input  logic                        nreset_i,
  input  logic                        start_i,
  input  logic                        px_rdy_i,
  input  logic [N_CH-1:0][DATA_W-1:0] px_i,
  output logic [N_CH-1:0][DATA_W-1:0] px_o,
  output logic                        px_rdy_o,
  output logic                        frame_done_o,
  output logic                        busy_o
);

  localparam int CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   col, col_n, eff_col;
  logic [RW-1:0]   row, row_n, eff_row;
  logic            accept, last_px;
  logic [LBW-1:0]  lb_idx;

  logic signed [DATA_W-1:0] hold     [N_CH];
  logic signed [DATA_W-1:0] relu_v   [N_CH];
  logic signed [DATA_W-1:0] pair_max [N_CH];
  logic signed [DATA_W-1:0] lb_rd    [N_CH];
  logic signed [DATA_W-1:0] pool_max [N_CH];
  logic signed [DATA_W-1:0] lb       [LB_DEPTH][N_CH];

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state <= IDLE;
    else           state <= state_n;
  end

  // A start in the same cycle as a pixel makes that pixel (0,0), so all
  // downstream logic works on the effective (post-restart) coordinates.
  always_comb begin
    state_n = state;
    accept  = px_rdy_i && (start_i || (state == RUN));
    eff_col = start_i ? '0 : col;
    eff_row = start_i ? '0 : row;
    last_px = accept && !start_i && (eff_col == COL_LAST) && (eff_row == ROW_LAST);
    col_n   = eff_col;
    row_n   = eff_row;
    lb_idx  = LBW'(eff_col >> 1);
    if (accept) begin
      if (eff_col == COL_LAST) begin
        col_n = '0;
        row_n = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      end else begin
        col_n = eff_col + 1'b1;
      end
    end
    case (state)
      IDLE:    if (start_i) state_n = RUN;
      RUN:     if (last_px) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    for (int ch = 0; ch < N_CH; ch++) begin
      relu_v[ch] = $signed(px_i[ch]);
`ifdef RELU_EN
      if (relu_v[ch] < 0) relu_v[ch] = '0;
`else
`endif
      pair_max[ch] = (hold[ch] > relu_v[ch]) ? hold[ch] : relu_v[ch];
      lb_rd[ch]    = lb[lb_idx][ch];
      pool_max[ch] = (lb_rd[ch] > pair_max[ch]) ? lb_rd[ch] : pair_max[ch];
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col          <= '0;
      row          <= '0;
      px_o         <= '0;
      px_rdy_o     <= 1'b0;
      frame_done_o <= 1'b0;
      for (int ch = 0; ch < N_CH; ch++) hold[ch] <= '0;
    end else begin
      col          <= col_n;
      row          <= row_n;
      px_rdy_o     <= accept && eff_col[0] && eff_row[0];
      frame_done_o <= last_px;
      if (accept) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (!eff_col[0])    hold[ch] <= relu_v[ch];
          else if (eff_row[0]) px_o[ch] <= pool_max[ch];
        end
      end
    end
  end

  // Line buffer is deliberately unreset: every odd-row read follows an even-row write to the same entry.
  always_ff @(posedge clk_i) begin
    if (accept && eff_col[0] && !eff_row[0]) begin
      for (int ch = 0; ch < N_CH; ch++) lb[lb_idx][ch] <= pair_max[ch];
    end
  end

  assign busy_o = (state == RUN);

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Bench for relu_maxpool_2x2: table-driven 4x4 frames plus restart, reset and 5x5 odd-size sequences,
// with expected pooled pixels queued at the (odd,odd) input and checked when px_rdy_o fires.
module tb_relu_maxpool_2x2;
  localparam int N_CH = 16;
  localparam int DW   = 10;

  typedef logic [N_CH-1:0][DW-1:0] pix_t;
  typedef struct { pix_t data; int cyc; } exp_t;
  typedef struct { string name; int gap; bit neg; logic [3:0][DW-1:0] expv; } vec_t;

  localparam logic [DW-1:0] NEG_IN = 10'h3C0;
`ifdef RELU_EN
  localparam logic [DW-1:0] NEG_EXP = 10'h000;
`else
  localparam logic [DW-1:0] NEG_EXP = 10'h3C0;
`endif

  logic clk = 1'b0;
  logic nreset;
  logic start4, rdy4, start5, rdy5;
  pix_t px4_in, px4_out, px5_in, px5_out;
  logic prdy4, done4, busy4, prdy5, done5, busy5;

  exp_t q4[$];
  exp_t q5[$];
  exp_t e4, e5;
  vec_t tbl[3];
  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  logic [3:0][DW-1:0] ramp4, ramp5;

  relu_maxpool_2x2 #(.N_CH(N_CH), .DATA_W(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .nreset_i(nreset), .start_i(start4), .px_rdy_i(rdy4), .px_i(px4_in),
    .px_o(px4_out), .px_rdy_o(prdy4), .frame_done_o(done4), .busy_o(busy4));

  relu_maxpool_2x2 #(.N_CH(N_CH), .DATA_W(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk_i(clk), .nreset_i(nreset), .start_i(start5), .px_rdy_i(rdy5), .px_i(px5_in),
    .px_o(px5_out), .px_rdy_o(prdy5), .frame_done_o(done5), .busy_o(busy5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [N_CH*DW-1:0] act, input logic [N_CH*DW-1:0] expd);
    ntests++;
    if (act !== expd) begin
      nfail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expd);
    end
  endtask

  function automatic pix_t mkpix(input logic [DW-1:0] v, input bit neg, input logic [DW-1:0] negv);
    pix_t r;
    for (int c = 0; c < N_CH; c++) r[c] = (neg && c == 3) ? negv : v;
    return r;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic rdy, input pix_t v);
    if (!sel) begin start4 = st; rdy4 = rdy; px4_in = v; end
    else      begin start5 = st; rdy5 = rdy; px5_in = v; end
  endtask

  // Output arriving with nothing queued means the DUT produced a pixel it should not have.
  always @(negedge clk) begin
    if (prdy4) begin
      if (q4.size() == 0) checkOutput("unexpected_px_rdy4", 1, 0);
      else begin
        e4 = q4.pop_front();
        checkOutput("px4_data", px4_out, e4.data);
        checkOutput("px4_latency", cyc, e4.cyc);
      end
    end
    if (prdy5) begin
      if (q5.size() == 0) checkOutput("unexpected_px_rdy5", 1, 0);
      else begin
        e5 = q5.pop_front();
        checkOutput("px5_data", px5_out, e5.data);
        checkOutput("px5_latency", cyc, e5.cyc);
      end
    end
  end

  task automatic applyStimulus(input bit sel, input int w, input int npix, input int gap,
                               input bit neg, input bit first_start, input bit expect_out,
                               input bit check_done, input logic [3:0][DW-1:0] expv);
    for (int p = 0; p < npix; p++) begin
      int row;
      int col;
      row = p / w;
      col = p % w;
      @(negedge clk);
      drive(sel, first_start && p == 0, 1'b1, mkpix(DW'(row * w + col), neg, NEG_IN));
      if (expect_out && (row % 2 == 1) && (col % 2 == 1)) begin
        if (!sel) q4.push_back('{mkpix(expv[(row / 2) * 2 + col / 2], neg, NEG_EXP), cyc + 1});
        else      q5.push_back('{mkpix(expv[(row / 2) * 2 + col / 2], neg, NEG_EXP), cyc + 1});
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, '0);
      end
    end
    if (gap == 0) begin
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, '0);
    end
    if (check_done) begin
      checkOutput(sel ? "frame_done5" : "frame_done4", sel ? done5 : done4, 1);
      checkOutput(sel ? "busy5_after" : "busy4_after", sel ? busy5 : busy4, 0);
      @(negedge clk);
      checkOutput(sel ? "frame_done5_width" : "frame_done4_width", sel ? done5 : done4, 0);
    end
  endtask

  initial begin
    ramp4 = {10'd15, 10'd13, 10'd7, 10'd5};
    ramp5 = {10'd18, 10'd16, 10'd8, 10'd6};
    tbl[0] = '{"ramp",   0, 1'b0, ramp4};
    tbl[1] = '{"neg_ch3", 0, 1'b1, ramp4};
    tbl[2] = '{"gapped", 1, 1'b0, ramp4};

    nreset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    checkOutput("reset_px4", px4_out, '0);
    checkOutput("reset_prdy4", prdy4, 0);
    checkOutput("reset_done4", done4, 0);
    checkOutput("reset_busy4", busy4, 0);
    checkOutput("reset_px5", px5_out, '0);
    checkOutput("reset_busy5", busy5, 0);
    nreset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4, 16, tbl[i].gap, tbl[i].neg, 1'b1, 1'b1, 1'b1, tbl[i].expv);
      checkOutput({tbl[i].name, "_drained"}, q4.size(), 0);
    end

    // Restart: abort after 5 pixels, lone start in RUN, then a frame with no further start.
    applyStimulus(1'b0, 4, 5, 0, 1'b0, 1'b1, 1'b1, 1'b0, ramp4);
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, '0);
    checkOutput("busy4_restart", busy4, 1);
    applyStimulus(1'b0, 4, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1, ramp4);
    checkOutput("restart_drained", q4.size(), 0);

    // Reset mid-frame after 9 pixels; pixels without start afterward must be ignored.
    applyStimulus(1'b0, 4, 9, 0, 1'b0, 1'b1, 1'b1, 1'b0, ramp4);
    @(negedge clk); nreset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_px4", px4_out, '0);
    checkOutput("midreset_prdy4", prdy4, 0);
    checkOutput("midreset_busy4", busy4, 0);
    checkOutput("midreset_done4", done4, 0);
    nreset = 1'b1;
    checkOutput("midreset_drained", q4.size(), 0);
    applyStimulus(1'b0, 4, 16, 0, 1'b0, 1'b0, 1'b0, 1'b0, ramp4);
    checkOutput("idle_ignores_busy4", busy4, 0);
    checkOutput("idle_ignores_done4", done4, 0);
    applyStimulus(1'b0, 4, 16, 0, 1'b0, 1'b1, 1'b1, 1'b1, ramp4);

    applyStimulus(1'b1, 5, 25, 0, 1'b0, 1'b1, 1'b1, 1'b1, ramp5);

    repeat (3) @(negedge clk);
    checkOutput("final_drained4", q4.size(), 0);
    checkOutput("final_drained5", q5.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
